// File: rtl/reduce_gate_unit.sv
// Registered WIDTH-bit reduction gate (AND/NAND/OR/NOR/XOR/XNOR) with valid/ready
// handshake, plus an exhaustive sweep engine that counts patterns giving 1.
module reduce_gate_unit #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             c,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [WIDTH:0]   ones_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } state_t;

    localparam logic [WIDTH:0] LAST_PATTERN = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] ONE          = {{WIDTH{1'b0}}, 1'b1};

    // Codes 110 and 111 fall through to NAND, the legacy gate behaviour.
    function automatic logic reduce_fn(input logic [2:0] m, input logic [WIDTH-1:0] v);
        case (m)
            3'b000:  return &v;
            3'b001:  return ~&v;
            3'b010:  return |v;
            3'b011:  return ~|v;
            3'b100:  return ^v;
            3'b101:  return ~^v;
            default: return ~&v;
        endcase
    endfunction

    state_t         r_state;
    state_t         w_next_state;
    logic [WIDTH:0] r_pattern;
    logic [WIDTH:0] r_ones;
    logic [2:0]     r_sweep_mode;
    logic           r_out_valid;
    logic           r_c;
    logic           w_busy;
    logic           w_done;
    logic           w_xfer;
    logic           w_data_fn;
    logic           w_sweep_fn;

    assign w_data_fn  = reduce_fn(mode, a);
    assign w_sweep_fn = reduce_fn(r_sweep_mode, r_pattern[WIDTH-1:0]);
    assign in_ready   = !w_busy && (!r_out_valid || out_ready);
    assign w_xfer     = in_valid && in_ready;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sweep_start) w_next_state = S_SWEEP;
            end
            S_SWEEP: begin
                w_busy = 1'b1;
                if (r_pattern == LAST_PATTERN) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Pattern counter is one bit wider than the operand so the last pattern never aliases 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pattern    <= '0;
            r_ones       <= '0;
            r_sweep_mode <= 3'b000;
        end else if (r_state == S_IDLE && sweep_start) begin
            r_pattern    <= '0;
            r_ones       <= '0;
            r_sweep_mode <= mode;
        end else if (r_state == S_SWEEP) begin
            r_pattern <= r_pattern + ONE;
            r_ones    <= r_ones + {{WIDTH{1'b0}}, w_sweep_fn};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_c         <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_c         <= w_data_fn;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign c          = r_c;
    assign sweep_busy = w_busy;
    assign sweep_done = w_done;
    assign ones_count = r_ones;

endmodule
